// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the integer decode stage.
//   alu_op_t       - ALU control code shared by the I-type and R-type forms
//   OPC_*          - major opcodes handled by the decoder
//   F7_*           - funct7 patterns for the base and alternate (SUB/SRA) forms
//   decode_entry_t - one decoded instruction (immediate held at 64 bits;
//                    consumers slice it to XLEN)
package decode_pkg;

    localparam int ALU_CTRL_W = 5;
    localparam int IMM_MAX_W  = 64;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic [IMM_MAX_W-1:0] imm;
        logic                 use_imm;
        alu_op_t              alu;
        logic                 illegal;
    } decode_entry_t;

endpackage

// File: rtl/decode_exec_pipe_field_decode.sv
// instr_field_decode: purely combinational field decode of one 32-bit word.
//   instr - instruction word
//   entry - register indices, sign/zero-extended immediate, ALU code,
//           operand-B select and illegal flag
module instr_field_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]   instr,
    output decode_entry_t entry
);

    localparam bit IS64 = (XLEN == 64);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] shamt;
    logic [6:0] shift_hi;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign shamt  = IS64 ? instr[25:20] : {1'b0, instr[24:20]};
    // Funct bits above the shamt, normalised to a 7-bit funct7 shape so the
    // same F7_BASE/F7_ALT compare works for both widths. On RV32 instr[25]
    // stays in the compare, which rejects shamt >= 32.
    assign shift_hi = IS64 ? {instr[31:26], 1'b0} : funct7;

    always_comb begin
        entry         = '0;
        entry.rs1     = instr[19:15];
        entry.rs2     = instr[24:20];
        entry.rd      = instr[11:7];
        entry.imm     = {{(IMM_MAX_W-12){instr[31]}}, instr[31:20]};
        entry.use_imm = 1'b0;
        entry.alu     = ALU_ADD;
        entry.illegal = 1'b0;

        case (opcode)
            OPC_OP_IMM: begin
                entry.rs2     = 5'd0;
                entry.use_imm = 1'b1;
                case (funct3)
                    3'd0: entry.alu = ALU_ADD;
                    3'd2: entry.alu = ALU_SLT;
                    3'd3: entry.alu = ALU_SLTU;
                    3'd4: entry.alu = ALU_XOR;
                    3'd6: entry.alu = ALU_OR;
                    3'd7: entry.alu = ALU_AND;
                    3'd1: begin
                        entry.alu     = ALU_SLL;
                        entry.imm     = {{(IMM_MAX_W-6){1'b0}}, shamt};
                        entry.illegal = (shift_hi != F7_BASE);
                    end
                    default: begin // 3'd5
                        entry.alu     = instr[30] ? ALU_SRA : ALU_SRL;
                        entry.imm     = {{(IMM_MAX_W-6){1'b0}}, shamt};
                        entry.illegal = (shift_hi != F7_BASE) && (shift_hi != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                entry.imm = '0;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'd0:    entry.alu = ALU_ADD;
                        3'd1:    entry.alu = ALU_SLL;
                        3'd2:    entry.alu = ALU_SLT;
                        3'd3:    entry.alu = ALU_SLTU;
                        3'd4:    entry.alu = ALU_XOR;
                        3'd5:    entry.alu = ALU_SRL;
                        3'd6:    entry.alu = ALU_OR;
                        default: entry.alu = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                    entry.alu = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                    entry.alu = ALU_SRA;
                end else begin
                    entry.illegal = 1'b1;
                end
            end
            default: entry.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_exec_pipe.sv
// decode_exec_pipe: registered decode stage with a one-entry skid buffer.
//   clk, reset           - clock, synchronous active-high reset
//   flush                - drop every held entry (branch redirect)
//   in_valid/in_ready    - upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready  - downstream handshake
//   out_rs1/rs2/rd       - register indices
//   out_imm, out_use_imm - operand-B immediate and its select
//   out_alu_control      - ALU operation code
//   out_illegal          - unsupported encoding (still delivered in order)
//   out_pc               - pc of the presented entry
module decode_exec_pipe
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ALU_W = 5,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_use_imm,
    output logic [ALU_W-1:0] out_alu_control,
    output logic             out_illegal,
    output logic [PC_W-1:0]  out_pc
);

    decode_entry_t dec_entry;
    decode_entry_t or_entry, sr_entry;
    logic [PC_W-1:0] or_pc, sr_pc;
    logic            or_valid, sr_valid;
    logic            accept, pop;
    logic            unused_imm_bits;

    instr_field_decode #(.XLEN(XLEN)) u_field_decode (
        .instr (in_instr),
        .entry (dec_entry)
    );

    // in_ready comes straight from the SR valid flop, so it never sees
    // out_ready combinationally.
    assign in_ready = !sr_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = or_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
            or_entry <= '0;
            sr_entry <= '0;
            or_pc    <= '0;
            sr_pc    <= '0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
        end else if (pop || !or_valid) begin
            // OR frees up: oldest held entry moves forward first.
            if (sr_valid) begin
                or_entry <= sr_entry;
                or_pc    <= sr_pc;
                or_valid <= 1'b1;
                sr_valid <= accept;
                if (accept) begin
                    sr_entry <= dec_entry;
                    sr_pc    <= in_pc;
                end
            end else begin
                or_valid <= accept;
                if (accept) begin
                    or_entry <= dec_entry;
                    or_pc    <= in_pc;
                end
            end
        end else if (accept) begin
            // OR stalled: park the new entry in the skid slot.
            sr_entry <= dec_entry;
            sr_pc    <= in_pc;
            sr_valid <= 1'b1;
        end
    end

    assign out_valid       = or_valid;
    assign out_rs1         = or_entry.rs1;
    assign out_rs2         = or_entry.rs2;
    assign out_rd          = or_entry.rd;
    assign out_imm         = or_entry.imm[XLEN-1:0];
    assign out_use_imm     = or_entry.use_imm;
    assign out_alu_control = ALU_W'(or_entry.alu);
    assign out_illegal     = or_entry.illegal;
    assign out_pc          = or_pc;

    // Immediate bits above XLEN are only meaningful on RV64.
    assign unused_imm_bits = ^or_entry.imm;

endmodule

// File: tb/tb_decode_exec_pipe.sv
// tb_decode_exec_pipe: directed vectors with hand-computed expectations for
// decode_exec_pipe (XLEN=32). Inputs change and outputs are sampled on the
// falling edge.
module tb_decode_exec_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_imm, out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_control;
    logic        out_use_imm, out_illegal;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_exec_pipe #(.XLEN(32), .ALU_W(5), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_use_imm(out_use_imm),
        .out_alu_control(out_alu_control), .out_illegal(out_illegal), .out_pc(out_pc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one instruction for a single cycle with out_ready high; on
    // return the entry should be on the outputs.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_instr  = instr;
        in_pc     = pc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic chk_dec(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm, input logic [4:0] alu,
                           input logic use_imm, input logic ill, input logic [31:0] pc);
        chk({tag, ".valid"},   out_valid, 1'b1);
        chk({tag, ".rd"},      out_rd, rd);
        chk({tag, ".rs1"},     out_rs1, rs1);
        chk({tag, ".rs2"},     out_rs2, rs2);
        chk({tag, ".imm"},     out_imm, imm);
        chk({tag, ".alu"},     out_alu_control, alu);
        chk({tag, ".use_imm"}, out_use_imm, use_imm);
        chk({tag, ".illegal"}, out_illegal, ill);
        chk({tag, ".pc"},      out_pc, pc);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".valid"},    out_valid, 1'b0);
        chk({tag, ".in_ready"}, in_ready, 1'b1);
        chk({tag, ".rd"},       out_rd, 5'd0);
        chk({tag, ".rs1"},      out_rs1, 5'd0);
        chk({tag, ".imm"},      out_imm, 32'd0);
        chk({tag, ".alu"},      out_alu_control, 5'd0);
        chk({tag, ".pc"},       out_pc, 32'd0);
    endtask

    // Two accepts with out_ready low: OR and SR both full afterwards.
    task automatic fill_both();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF10093;
        in_pc     = 32'h200;
        @(negedge clk);
        in_pc     = 32'h204;
        @(negedge clk);
        in_valid  = 1'b0;
        chk("fill.in_ready", in_ready, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        reset = 1'b0;

        // ALU codes: ADD=0 SUB=1 SLL=2 SRL=6 SRA=7 AND=9
        issue(32'hFFF10093, 32'h1000);  // addi x1,x2,-1
        chk_dec("addi", 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, 32'h1000);
        issue(32'h40335293, 32'h1004);  // srai x5,x6,3
        chk_dec("srai", 5'd5, 5'd6, 5'd0, 32'd3, 5'd7, 1'b1, 1'b0, 32'h1004);
        issue(32'h00335293, 32'h1008);  // srli x5,x6,3
        chk_dec("srli", 5'd5, 5'd6, 5'd0, 32'd3, 5'd6, 1'b1, 1'b0, 32'h1008);
        issue(32'h402081B3, 32'h100C);  // sub x3,x1,x2
        chk_dec("sub", 5'd3, 5'd1, 5'd2, 32'd0, 5'd1, 1'b0, 1'b0, 32'h100C);
        issue(32'h002081B3, 32'h1010);  // add x3,x1,x2
        chk_dec("add", 5'd3, 5'd1, 5'd2, 32'd0, 5'd0, 1'b0, 1'b0, 32'h1010);
        issue(32'h7FF47393, 32'h1014);  // andi x7,x8,0x7ff
        chk_dec("andi", 5'd7, 5'd8, 5'd0, 32'h7FF, 5'd9, 1'b1, 1'b0, 32'h1014);
        issue(32'h4020C1B3, 32'h1018);  // funct7 alt with funct3=4
        chk("alt_xor.illegal", out_illegal, 1'b1);
        issue(32'h02009093, 32'h101C);  // slli with instr[25]=1 on RV32
        chk("slli_hi.illegal", out_illegal, 1'b1);
        chk("slli_hi.alu",     out_alu_control, 5'd2);
        issue(32'h00000073, 32'h1020);  // ecall
        chk_dec("ecall", 5'd0, 5'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'h1020);
        @(negedge clk);                  // ecall popped
        chk("ecall.popped", out_valid, 1'b0);

        // Backpressure: three back-to-back inputs, out_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF10093;
        in_pc     = 32'h100;
        @(negedge clk);
        chk("bp.ready1", in_ready, 1'b1);
        in_pc = 32'h104;
        @(negedge clk);
        chk("bp.ready2", in_ready, 1'b0);
        chk("bp.head", out_pc, 32'h100);
        in_pc = 32'h108;
        @(negedge clk);
        chk("bp.ready3", in_ready, 1'b0);
        chk("bp.hold_pc", out_pc, 32'h100);
        chk("bp.hold_v",  out_valid, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.pop1_pc", out_pc, 32'h104);
        chk("bp.pop1_rd", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.pop2_pc", out_pc, 32'h108);
        chk("bp.pop2_v",  out_valid, 1'b1);
        @(negedge clk);
        chk("bp.drain", out_valid, 1'b0);

        // Flush with both slots full and a concurrent valid input.
        fill_both();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h300;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.valid", out_valid, 1'b0);
        chk("flush.ready", in_ready, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush.no_stale", out_valid, 1'b0);
        issue(32'h00335293, 32'h400);
        chk("flush.next_pc", out_pc, 32'h400);
        chk("flush.next_alu", out_alu_control, 5'd6);
        @(negedge clk);

        // Reset in the middle of a stall.
        fill_both();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_cleared("reset_stall");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_exec_pipe.md
Name: decode_exec_pipe

Overview:
- Pipelined integer decode stage for the RV32/RV64 core. Decodes OP-IMM (I-type, including shifts) and OP (R-type) instructions into register indices, a sign-extended XLEN immediate and an ALU control code.
- Decoded results are registered behind a valid/ready handshake. A skid entry gives full throughput under backpressure.
- Sits between the fetch buffer and the register-read/execute stage.

Parameters:
- XLEN, 32, datapath width. Legal values are 32 or 64. Sets the immediate width and the shamt width (5 bits for 32, 6 bits for 64).
- ALU_W, 5, width of the ALU control code. Must match the package constant.
- PC_W, 32, width of the pc sideband carried with each instruction.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discards all held entries (branch redirect)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  pc of in_instr
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_rs1  out  5  source register 1
- out_rs2  out  5  source register 2 (0 for OP-IMM)
- out_rd  out  5  destination register
- out_imm  out  XLEN  sign-extended immediate; zero-extended shamt for shifts; 0 for OP
- out_use_imm  out  1  1 = ALU operand B is out_imm
- out_alu_control  out  ALU_W  ALU operation code
- out_illegal  out  1  unsupported opcode or funct7
- out_pc  out  PC_W  pc of the decoded entry

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Storage: output register (OR) plus one skid register (SR). Entries are popped in strict FIFO order.
- Reset values: out_valid=0, SR empty, all data outputs 0, in_ready=1 in the first cycle after reset.
- in_ready = !SR_full. It is registered and does not combinationally depend on out_ready.
- Accept: in_valid && in_ready. Latency is 1 cycle: an accepted instruction appears on the outputs the next cycle if OR is empty or is popping that cycle; otherwise it goes to SR.
- Pop: out_valid && out_ready. On a pop, SR moves to OR. With a pop and an accept in the same cycle, SR refills with the accepted entry (SR-full case) or OR takes it directly.
- Hold: data outputs stay stable while out_valid && !out_ready.
- Flush: OR and SR are invalidated next cycle and any input accepted in the flush cycle is dropped. in_ready=1 in the next cycle. Flush has priority over accept; reset has priority over flush.
- OP-IMM decode (opcode 7'b0010011), funct3 to code:
  - 0 ADDI, 2 SLTI, 3 SLTIU, 4 XORI, 6 ORI, 7 ANDI
  - 1 SLLI
  - 5 SRLI when instr[30]=0, SRAI when instr[30]=1
- OP-IMM immediates:
  - Non-shift: out_imm = sign-extend(instr[31:20]) to XLEN.
  - Shifts: out_imm = zero-extend(shamt), with shamt = instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
- OP-IMM illegal conditions:
  - SLLI with the upper funct bits nonzero.
  - SRLI/SRAI with upper bits other than 0000000 or 0100000 (after excluding the shamt bits).
  - XLEN=32 with instr[25]=1 on any shift.
- OP decode (opcode 7'b0110011):
  - funct7 0000000 gives ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by funct3.
  - funct7 0100000 is legal only for funct3 0 (SUB) and 5 (SRA).
  - Any other funct7 is illegal. out_use_imm=0.
- Any other opcode: out_illegal=1, out_alu_control=ALU_ADD. All other fields are still extracted verbatim.
- Illegal entries flow through the handshake like any other entry and are never dropped.

Decomposition:
- Package decode_pkg holds:
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, encoded 0–9, ALU_W bits.
  - Opcode constants OPC_OP_IMM and OPC_OP.
  - funct7 constants F7_BASE and F7_ALT.
  - The decoded-entry struct decode_entry_t.
- I-type and R-type forms share ALU codes (ADDI→ADD, and so on). out_use_imm tells them apart.
- Sub-module: instr_field_decode, purely combinational, instr → decode_entry_t, parameterised by XLEN. The top holds only the OR/SR handshake logic.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), out_ready=1 → next cycle: rd=1, rs1=2, imm=0xFFFFFFFF, ALU_ADD, use_imm=1, illegal=0.
- srai x5,x6,3 (0x40335293) → rd=5, rs1=6, imm=3, ALU_SRA. The same word with instr[30]=0 (0x00335293) → ALU_SRL.
- sub x3,x1,x2 (0x402081B3) → ALU_SUB, rs2=2, use_imm=0. With funct7 0100000 and funct3 4 (0x4020C1B3) → illegal=1.
- ecall (0x00000073) → illegal=1, ALU_ADD, entry still presented and popped.
- out_ready=0 with 3 back-to-back valid inputs → the first 2 are accepted, in_ready=0 on the third. Raise out_ready → outputs appear in order, one per cycle, no loss or duplication.
- OR and SR full, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, no stale entry emitted. Repeat with reset mid-stall → all outputs return to 0.
